// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x5 keypad scanner and its debouncer.
package keypad_pkg;

  localparam int N_ROW = 4;
  localparam int N_COL = 5;
  localparam logic [4:0] KEY_NONE = 5'd0;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_CAND    = 2'd1,
    ST_PRESSED = 2'd2,
    ST_RELEASE = 2'd3
  } kp_state_e;

  // 1-based key code: row*N_COL + col + 1
  function automatic logic [4:0] key_code(input logic [1:0] row, input logic [2:0] col);
    logic [4:0] row5;
    row5 = {3'd0, row};
    return row5 * 5'(N_COL) + {2'd0, col} + 5'd1;
  endfunction

endpackage

// File: rtl/keypad_debounce.sv
// Frame-level debounce FSM: accepts a key after DEB_SCANS identical frames and
// emits one valid pulse. Optional auto-repeat is enabled by defining AUTO_REPEAT_EN.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int DEB_SCANS   = 20,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic       i_tick,
  input  logic [4:0] i_code,
  output logic       o_key_valid,
  output logic [4:0] o_key_value,
  output kp_state_e  o_state
);

  localparam int CW = $clog2(DEB_SCANS + 1);
  localparam logic [CW-1:0] DEB_MAX = CW'(DEB_SCANS);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  kp_state_e     r_state, w_state_nxt;
  logic [4:0]    r_cand, w_cand_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt, w_cnt_inc;
  logic [4:0]    r_value, w_value_nxt;
  logic          r_valid, w_valid_nxt;
  logic          w_enter_pressed;
  logic          w_rep_fire;

  // Handshake: o_key_valid is a single-cycle strobe with no back-pressure;
  // o_key_value is valid whenever o_key_valid is high and holds until the next event.
  assign o_key_valid = r_valid;
  assign o_key_value = r_value;
  assign o_state     = r_state;
  assign w_cnt_inc   = (r_cnt == DEB_MAX) ? r_cnt : r_cnt + CNT_ONE;

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_state <= ST_IDLE;
      r_cand  <= KEY_NONE;
      r_cnt   <= '0;
      r_value <= KEY_NONE;
      r_valid <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cand  <= w_cand_nxt;
      r_cnt   <= w_cnt_nxt;
      r_value <= w_value_nxt;
      r_valid <= w_valid_nxt | w_rep_fire;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cand_nxt      = r_cand;
    w_cnt_nxt       = r_cnt;
    w_value_nxt     = r_value;
    w_valid_nxt     = 1'b0;
    w_enter_pressed = 1'b0;
    if (i_tick) begin
      case (r_state)
        ST_IDLE: begin
          if (i_code != KEY_NONE) begin
            w_cand_nxt = i_code;
            if (DEB_MAX == CNT_ONE) begin
              w_state_nxt     = ST_PRESSED;
              w_value_nxt     = i_code;
              w_valid_nxt     = 1'b1;
              w_enter_pressed = 1'b1;
              w_cnt_nxt       = '0;
            end else begin
              w_state_nxt = ST_CAND;
              w_cnt_nxt   = CNT_ONE;
            end
          end
        end
        ST_CAND: begin
          if (i_code == r_cand) begin
            w_cnt_nxt = w_cnt_inc;
            if (w_cnt_inc == DEB_MAX) begin
              w_state_nxt     = ST_PRESSED;
              w_value_nxt     = r_cand;
              w_valid_nxt     = 1'b1;
              w_enter_pressed = 1'b1;
              w_cnt_nxt       = '0;
            end
          end else if (i_code != KEY_NONE) begin
            w_cand_nxt = i_code;
            w_cnt_nxt  = CNT_ONE;
          end else begin
            w_state_nxt = ST_IDLE;
            w_cnt_nxt   = '0;
          end
        end
        ST_PRESSED: begin
          // A different non-zero code while held is deliberately ignored.
          if (i_code == KEY_NONE) begin
            if (DEB_MAX == CNT_ONE) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_state_nxt = ST_RELEASE;
              w_cnt_nxt   = CNT_ONE;
            end
          end
        end
        default: begin
          if (i_code == KEY_NONE) begin
            if (w_cnt_inc == DEB_MAX) begin
              w_state_nxt = ST_IDLE;
              w_cnt_nxt   = '0;
            end else begin
              w_cnt_nxt = w_cnt_inc;
            end
          end else begin
            w_state_nxt = ST_PRESSED;
            w_cnt_nxt   = '0;
          end
        end
      endcase
    end
  end

`ifdef AUTO_REPEAT_EN
  localparam int RW = $clog2(REPEAT_DLY + REPEAT_RATE + 1);

  logic [RW-1:0] r_rep_cnt, w_rep_cnt_inc, w_rep_target;
  logic          r_rep_phase;

  assign w_rep_cnt_inc = r_rep_cnt + RW'(1);
  assign w_rep_target  = r_rep_phase ? RW'(REPEAT_RATE) : RW'(REPEAT_DLY);
  assign w_rep_fire    = i_tick && (r_state == ST_PRESSED) && (i_code != KEY_NONE) &&
                         (w_rep_cnt_inc == w_rep_target);

  // Counter freezes in RELEASE so a brief bounce resumes the same repeat cadence.
  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (w_enter_pressed || r_state == ST_IDLE) begin
      r_rep_cnt   <= '0;
      r_rep_phase <= 1'b0;
    end else if (i_tick && r_state == ST_PRESSED && i_code != KEY_NONE) begin
      if (w_rep_fire) begin
        r_rep_cnt   <= '0;
        r_rep_phase <= 1'b1;
      end else begin
        r_rep_cnt <= w_rep_cnt_inc;
      end
    end
  end
`else
  assign w_rep_fire = 1'b0;
`endif

endmodule

// File: rtl/keypad_scan.sv
// 4x5 active-low key matrix scanner: row sync, column drive, frame-code build,
// then keypad_debounce. Auto-repeat is built in when AUTO_REPEAT_EN is defined.
module keypad_scan
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV    = 50000,
  parameter int DEB_SCANS   = 20,
  parameter int REPEAT_DLY  = 50,
  parameter int REPEAT_RATE = 10
) (
  input  logic       i_clk,
  input  logic       i_rstn,
  input  logic [3:0] i_row,
  output logic [4:0] o_col,
  output logic       o_key_valid,
  output logic [4:0] o_key_value,
  output kp_state_e  o_dbg_state
);

  localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(SCAN_DIV - 1);

  logic [3:0]    r_row_s1, r_row_s2;
  logic [DW-1:0] r_div;
  logic [2:0]    r_col;
  logic [1:0]    r_acc_cnt;
  logic [4:0]    r_acc_code;
  logic [4:0]    r_frame_code;
  logic          r_frame_tick;

  logic       w_tc, w_frame_end;
  logic [3:0] w_hits;
  logic [2:0] w_nhit, w_sum;
  logic [1:0] w_hit_row, w_base_cnt, w_cnt_next;
  logic [4:0] w_base_code, w_code_next;

  assign w_tc        = (r_div == DIV_LAST);
  assign w_frame_end = w_tc && (r_col == 3'd4);
  assign o_col       = ~(5'b00001 << r_col);

  // Accumulate hits across the 5 slots; count saturates at 2 meaning "multi-press".
  always_comb begin
    w_hits    = ~r_row_s2;
    w_nhit    = 3'd0;
    w_hit_row = 2'd0;
    for (int r = 0; r < N_ROW; r++) begin
      if (w_hits[r]) begin
        w_nhit    = w_nhit + 3'd1;
        w_hit_row = 2'(r);
      end
    end
    w_base_cnt  = (r_col == 3'd0) ? 2'd0 : r_acc_cnt;
    w_base_code = (r_col == 3'd0) ? KEY_NONE : r_acc_code;
    w_sum       = {1'b0, w_base_cnt} + w_nhit;
    w_cnt_next  = (w_sum >= 3'd2) ? 2'd2 : w_sum[1:0];
    w_code_next = (w_base_cnt == 2'd0 && w_nhit == 3'd1) ? key_code(w_hit_row, r_col)
                                                         : w_base_code;
  end

  always_ff @(posedge i_clk or negedge i_rstn) begin
    if (!i_rstn) begin
      r_row_s1     <= 4'hF;
      r_row_s2     <= 4'hF;
      r_div        <= '0;
      r_col        <= 3'd0;
      r_acc_cnt    <= 2'd0;
      r_acc_code   <= KEY_NONE;
      r_frame_code <= KEY_NONE;
      r_frame_tick <= 1'b0;
    end else begin
      r_row_s1     <= i_row;
      r_row_s2     <= r_row_s1;
      r_frame_tick <= w_frame_end;
      if (w_tc) begin
        r_div      <= '0;
        r_col      <= (r_col == 3'd4) ? 3'd0 : r_col + 3'd1;
        r_acc_cnt  <= w_cnt_next;
        r_acc_code <= w_code_next;
      end else begin
        r_div <= r_div + DW'(1);
      end
      if (w_frame_end) begin
        r_frame_code <= (w_cnt_next == 2'd1) ? w_code_next : KEY_NONE;
      end
    end
  end

  keypad_debounce #(
    .DEB_SCANS  (DEB_SCANS),
    .REPEAT_DLY (REPEAT_DLY),
    .REPEAT_RATE(REPEAT_RATE)
  ) u_debounce (
    .i_clk      (i_clk),
    .i_rstn     (i_rstn),
    .i_tick     (r_frame_tick),
    .i_code     (r_frame_code),
    .o_key_valid(o_key_valid),
    .o_key_value(o_key_value),
    .o_state    (o_dbg_state)
  );

endmodule

// File: tb/tb_keypad_scan.sv
// Directed bench for keypad_scan with SCAN_DIV=4 (20-clock frames), DEB_SCANS=3.
module tb_keypad_scan;
  import keypad_pkg::*;

  logic       clk = 1'b0;
  logic       rstn;
  logic [3:0] row;
  logic [4:0] col;
  logic       kv;
  logic [4:0] kval;
  kp_state_e  st;
  logic [20:1] keys;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_cyc = 0;
  int double_cnt = 0;
  logic [4:0] last_val = 5'd0;
  logic prev_kv = 1'b0;
  int t0, p0;

  logic [4:0] col_tab [5] = '{5'b11110, 5'b11101, 5'b11011, 5'b10111, 5'b01111};

`ifdef AUTO_REPEAT_EN
  localparam int REP_N = 5;
  localparam int REP_LAST = 281;
`else
  localparam int REP_N = 1;
  localparam int REP_LAST = 61;
`endif

  // clock / reset
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // key matrix model: a pressed key pulls its row low while its column is driven
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 5; c++)
        if (keys[r*5+c+1] && !col[c]) row[r] = 1'b0;
  end

  keypad_scan #(.SCAN_DIV(4), .DEB_SCANS(3), .REPEAT_DLY(5), .REPEAT_RATE(2)) dut (
    .i_clk      (clk),
    .i_rstn     (rstn),
    .i_row      (row),
    .o_col      (col),
    .o_key_valid(kv),
    .o_key_value(kval),
    .o_dbg_state(st)
  );

  // pulse monitor
  always @(negedge clk) begin
    if (kv) begin
      pulse_cnt = pulse_cnt + 1;
      last_val  = kval;
      last_cyc  = cyc;
      if (prev_kv) double_cnt = double_cnt + 1;
    end
    prev_kv = kv;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic sync_frame();
    logic [4:0] prev;
    logic found;
    prev  = col;
    found = 1'b0;
    for (int i = 0; i < 60 && !found; i++) begin
      @(negedge clk);
      if (col == 5'b11110 && prev == 5'b01111) found = 1'b1;
      prev = col;
    end
    #1;
    check("frame_sync", {31'd0, found}, 32'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rstn = 1'b0;
    keys = '0;
    wait_cyc(3);
    check("rst_col", col, 5'b11110);
    check("rst_valid", kv, 1'b0);
    check("rst_value", kval, 5'd0);
    check("rst_state", st, ST_IDLE);
    rstn = 1'b1;

    // 1: idle scan sequence
    for (int s = 0; s < 6; s++) begin
      wait_cyc(4);
      check("scan_col", col, col_tab[(s+1)%5]);
    end
    wait_cyc(40);
    check("idle_pulses", pulse_cnt, 0);
    check("idle_value", kval, 5'd0);

    // 2: key 14 (row2/col3) held 5 frames, then released
    sync_frame();
    keys[14] = 1'b1; t0 = cyc; p0 = pulse_cnt;
    wait_cyc(100);
    check("k14_pulses", pulse_cnt - p0, 1);
    check("k14_value", last_val, 5'd14);
    check("k14_latency", last_cyc - t0, 61);
    check("k14_state", st, ST_PRESSED);
    keys = '0; p0 = pulse_cnt;
    wait_cyc(80);
    check("k14_rel_pulses", pulse_cnt - p0, 0);
    check("k14_rel_state", st, ST_IDLE);
    check("k14_held_value", kval, 5'd14);

    // 3: bounce on key 7: 2 frames down, 1 up, 3 down
    keys[7] = 1'b1; p0 = pulse_cnt;
    wait_cyc(40);
    keys = '0;
    wait_cyc(20);
    check("k7_no_early", pulse_cnt - p0, 0);
    keys[7] = 1'b1; t0 = cyc;
    wait_cyc(80);
    check("k7_pulses", pulse_cnt - p0, 1);
    check("k7_value", last_val, 5'd7);
    check("k7_latency", last_cyc - t0, 61);
    keys = '0;
    wait_cyc(80);

    // 4: keys 1 and 20 together rejected, then key 1 alone
    keys[1] = 1'b1; keys[20] = 1'b1; p0 = pulse_cnt;
    wait_cyc(120);
    check("ghost_pulses", pulse_cnt - p0, 0);
    check("ghost_state", st, ST_IDLE);
    keys[20] = 1'b0; t0 = cyc;
    wait_cyc(80);
    check("k1_pulses", pulse_cnt - p0, 1);
    check("k1_value", last_val, 5'd1);
    check("k1_latency", last_cyc - t0, 61);
    keys = '0;
    wait_cyc(80);

    // 5: hold key 5, add key 9, release, press 9
    keys[5] = 1'b1; p0 = pulse_cnt;
    wait_cyc(80);
    check("k5_pulses", pulse_cnt - p0, 1);
    check("k5_value", last_val, 5'd5);
    keys[9] = 1'b1;
    wait_cyc(60);
    check("k5k9_pulses", pulse_cnt - p0, 1);
    keys = '0;
    wait_cyc(60);
    check("k5k9_rel_state", st, ST_IDLE);
    keys[9] = 1'b1; t0 = cyc;
    wait_cyc(80);
    check("k9_pulses", pulse_cnt - p0, 2);
    check("k9_value", last_val, 5'd9);
    check("k9_latency", last_cyc - t0, 61);
    keys = '0;
    wait_cyc(80);

    // async reset while in CAND
    keys[3] = 1'b1;
    wait_cyc(30);
    check("k3_cand_state", st, ST_CAND);
    #2 rstn = 1'b0;
    #1;
    check("mid_rst_col", col, 5'b11110);
    check("mid_rst_valid", kv, 1'b0);
    check("mid_rst_value", kval, 5'd0);
    check("mid_rst_state", st, ST_IDLE);
    keys = '0;
    wait_cyc(2);
    rstn = 1'b1;

    // 6: hold key 12 for 12 frames after acceptance
    sync_frame();
    keys[12] = 1'b1; t0 = cyc; p0 = pulse_cnt;
    wait_cyc(300);
    check("k12_pulses", pulse_cnt - p0, REP_N);
    check("k12_value", last_val, 5'd12);
    check("k12_last_pulse", last_cyc - t0, REP_LAST);
    keys = '0;
    wait_cyc(80);
    check("k12_rel_pulses", pulse_cnt - p0, REP_N);
    check("k12_rel_state", st, ST_IDLE);

    check("single_cycle_pulse", double_cnt, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
